// File: rtl/alu_share_if.sv
// Requester-side bundle for alu_share_arbiter: an operation request handshake
// plus the matching response handshake for one requester.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_src_a;
  logic [WIDTH-1:0] req_src_b;
  logic [3:0]       req_ctrl;
  logic             req_ign_exc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zero;
  logic             rsp_exc;
  logic [4:0]       rsp_exc_code;

  modport master (
    output req_valid, req_src_a, req_src_b, req_ctrl, req_ign_exc, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_exc, rsp_exc_code
  );

  modport slave (
    input  req_valid, req_src_a, req_src_b, req_ctrl, req_ign_exc, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_exc, rsp_exc_code
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between the EX stage (port 0) and the
// coprocessor path (port 1): registered issue stage, one response buffer per port.
module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_if.slave       io_port0,
  alu_share_if.slave       io_port1,
  output logic [WIDTH-1:0] o_alu_src_a,
  output logic [WIDTH-1:0] o_alu_src_b,
  output logic [3:0]       o_alu_ctrl,
  output logic             o_alu_ign_exc,
  input  logic [WIDTH-1:0] i_alu_res,
  input  logic             i_alu_zero,
  input  logic             i_alu_exc,
  input  logic [4:0]       i_alu_exc_code
);

  logic [1:0]            w_req_valid;
  logic [1:0]            w_rsp_ready;
  logic [1:0][WIDTH-1:0] w_src_a;
  logic [1:0][WIDTH-1:0] w_src_b;
  logic [1:0][3:0]       w_ctrl;
  logic [1:0]            w_ign_exc;
  logic [1:0]            w_inflight;
  logic [1:0]            w_elig;
  logic [1:0]            w_grant;
  logic [1:0]            w_drain;
  logic                  w_pick1;

  logic                  r_rr_ptr;
  logic                  r_vld_p1;
  logic                  r_owner_p1;
  logic [WIDTH-1:0]      r_src_a_p1;
  logic [WIDTH-1:0]      r_src_b_p1;
  logic [3:0]            r_ctrl_p1;
  logic                  r_ign_exc_p1;

  logic [1:0]            r_vld_p2;
  logic [1:0][WIDTH-1:0] r_res_p2;
  logic [1:0]            r_zero_p2;
  logic [1:0]            r_exc_p2;
  logic [1:0][4:0]       r_exc_code_p2;

  assign w_req_valid = {io_port1.req_valid,   io_port0.req_valid};
  assign w_rsp_ready = {io_port1.rsp_ready,   io_port0.rsp_ready};
  assign w_src_a     = {io_port1.req_src_a,   io_port0.req_src_a};
  assign w_src_b     = {io_port1.req_src_b,   io_port0.req_src_b};
  assign w_ctrl      = {io_port1.req_ctrl,    io_port0.req_ctrl};
  assign w_ign_exc   = {io_port1.req_ign_exc, io_port0.req_ign_exc};

  // A port with an op in the issue stage or a full buffer may not accept,
  // even if that buffer is being drained this very cycle.
  assign w_inflight = {r_vld_p1 & r_owner_p1, r_vld_p1 & ~r_owner_p1};
  assign w_elig     = w_req_valid & ~w_inflight & ~r_vld_p2;
  assign w_pick1    = FIXED_PRIO ? 1'b0 : r_rr_ptr;
  assign w_drain    = r_vld_p2 & w_rsp_ready;

  always_comb begin
    w_grant = 2'b00;
    if (rst_n) begin
      if (w_elig[0] && !(w_elig[1] && w_pick1)) begin
        w_grant[0] = 1'b1;
      end else if (w_elig[1]) begin
        w_grant[1] = 1'b1;
      end
    end
  end

  // p0 -> p1: accept into the issue stage that drives the shared ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_owner_p1   <= 1'b0;
      r_src_a_p1   <= '0;
      r_src_b_p1   <= '0;
      r_ctrl_p1    <= '0;
      r_ign_exc_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= |w_grant;
      if (|w_grant) begin
        r_rr_ptr     <= w_grant[0];
        r_owner_p1   <= w_grant[1];
        r_src_a_p1   <= w_src_a[w_grant[1]];
        r_src_b_p1   <= w_src_b[w_grant[1]];
        r_ctrl_p1    <= w_ctrl[w_grant[1]];
        r_ign_exc_p1 <= w_ign_exc[w_grant[1]];
      end
    end
  end

  // p1 -> p2: capture ALU outputs into the owner's response buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2      <= '0;
      r_res_p2      <= '0;
      r_zero_p2     <= '0;
      r_exc_p2      <= '0;
      r_exc_code_p2 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_inflight[i]) begin
          r_vld_p2[i]      <= 1'b1;
          r_res_p2[i]      <= i_alu_res;
          r_zero_p2[i]     <= i_alu_zero;
          r_exc_p2[i]      <= i_alu_exc;
          r_exc_code_p2[i] <= i_alu_exc_code;
        end else if (w_drain[i]) begin
          r_vld_p2[i] <= 1'b0;
        end
      end
    end
  end

  assign o_alu_src_a   = r_src_a_p1;
  assign o_alu_src_b   = r_src_b_p1;
  assign o_alu_ctrl    = r_ctrl_p1;
  assign o_alu_ign_exc = r_ign_exc_p1;

  assign io_port0.req_ready    = w_grant[0];
  assign io_port0.rsp_valid    = r_vld_p2[0];
  assign io_port0.rsp_res      = r_res_p2[0];
  assign io_port0.rsp_zero     = r_zero_p2[0];
  assign io_port0.rsp_exc      = r_exc_p2[0];
  assign io_port0.rsp_exc_code = r_exc_code_p2[0];

  assign io_port1.req_ready    = w_grant[1];
  assign io_port1.rsp_valid    = r_vld_p2[1];
  assign io_port1.rsp_res      = r_res_p2[1];
  assign io_port1.rsp_zero     = r_zero_p2[1];
  assign io_port1.rsp_exc      = r_exc_p2[1];
  assign io_port1.rsp_exc_code = r_exc_code_p2[1];

endmodule
